keypad_number_entry: RTL and testbench

KEYPAD_NUMBER_ENTRY -- requirements
Module: keypad_number_entry

---
 rtl/keypad_number_entry_pkg.sv | 44 ++++
 rtl/keypad_number_entry_scan_tick.sv | 31 +++
 rtl/keypad_number_entry.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_number_entry.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_number_entry_pkg.sv
// Shared types, defaults and helpers for the 4x4 keypad number-entry block.
package keypad_number_entry_pkg;

  localparam int unsigned SCAN_DIV_DEFAULT     = 50000;
  localparam int unsigned DEBOUNCE_CNT_DEFAULT = 4;
  localparam int unsigned LINE_W               = 4;
  localparam int unsigned CODE_W               = 4;
  localparam int unsigned HEX_W                = 16;

  // Scanner / debouncer states
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  // Result of decoding one column sample
  typedef struct packed {
    logic       single;
    logic [1:0] col;
  } col_decode_t;

  // Exactly one low column bit is a key; anything else (none or ghosting) is not
  function automatic col_decode_t decode_col(input logic [LINE_W-1:0] col_n);
    col_decode_t d;
    d.single = 1'b0;
    d.col    = 2'd0;
    case (col_n)
      4'b1110: begin d.single = 1'b1; d.col = 2'd0; end
      4'b1101: begin d.single = 1'b1; d.col = 2'd1; end
      4'b1011: begin d.single = 1'b1; d.col = 2'd2; end
      4'b0111: begin d.single = 1'b1; d.col = 2'd3; end
      default: begin d.single = 1'b0; d.col = 2'd0; end
    endcase
    return d;
  endfunction

  // Active-low one-cold row drive for row index r
  function automatic logic [LINE_W-1:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

endpackage

// File: rtl/keypad_number_entry_scan_tick.sv
// Dwell divider: registered tick high on the last cycle of every SCAN_DIV-cycle dwell.
module scan_tick
  import keypad_number_entry_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // Free-running dwell counter; tick is pre-decoded one cycle early so it is a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      if (cnt == CNT_W'(SCAN_DIV - 1)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      tick <= (cnt == CNT_W'(SCAN_DIV - 2));
    end
  end

endmodule

// File: rtl/keypad_number_entry.sv
// 4x4 keypad scanner with debounce, single-shot key events and a four-digit hex entry register.
module keypad_number_entry
  import keypad_number_entry_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = SCAN_DIV_DEFAULT,
  parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [LINE_W-1:0] COL,
  output logic [LINE_W-1:0] ROW,
  output logic [HEX_W-1:0]  hexs,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid
);

  localparam int unsigned CNT_W         = $clog2(DEBOUNCE_CNT + 1);
  localparam bit          SINGLE_SAMPLE = (DEBOUNCE_CNT == 1);

  logic [LINE_W-1:0] col_s1;
  logic [LINE_W-1:0] col_s2;
  logic              tick;

  kp_state_e         state;
  kp_state_e         state_next;
  logic [1:0]        r;
  logic [CODE_W-1:0] cand;
  logic [CNT_W-1:0]  cnt;

  col_decode_t       dec_c;
  logic [CODE_W-1:0] sample_code_c;
  logic              match_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic              cnt_done_c;

  logic              accept_c;
  logic              adv_r_c;
  logic              cand_load_c;
  logic [CNT_W-1:0]  cnt_next_c;

  // Dwell timing
  scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer for the asynchronous column lines (idle high)
  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1 <= 4'b1111;
      col_s2 <= 4'b1111;
    end else begin
      col_s1 <= COL;
      col_s2 <= col_s1;
    end
  end

  // Sample decode shared by next-state and output logic
  always_comb begin
    dec_c         = decode_col(col_s2);
    sample_code_c = {r, dec_c.col};
    match_c       = dec_c.single && (sample_code_c == cand);
    cnt_inc_c     = cnt + CNT_W'(1);
    cnt_done_c    = (cnt_inc_c == CNT_W'(DEBOUNCE_CNT));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SCAN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; transitions only happen on a dwell sample
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (dec_c.single) begin
            state_next = SINGLE_SAMPLE ? ST_PRESSED : ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!match_c) begin
            state_next = ST_SCAN;
          end else if (cnt_done_c) begin
            state_next = ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (!dec_c.single) begin
            state_next = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (dec_c.single) begin
            state_next = ST_PRESSED;
          end else if (cnt_done_c) begin
            state_next = ST_SCAN;
          end
        end
        default: state_next = ST_SCAN;
      endcase
    end
  end

  // Control outputs: row advance, candidate latch, match counter, key acceptance
  always_comb begin
    accept_c    = 1'b0;
    adv_r_c     = 1'b0;
    cand_load_c = 1'b0;
    cnt_next_c  = cnt;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (dec_c.single) begin
            cand_load_c = 1'b1;
            if (SINGLE_SAMPLE) begin
              accept_c   = 1'b1;
              cnt_next_c = '0;
            end else begin
              cnt_next_c = CNT_W'(1);
            end
          end else begin
            adv_r_c = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!match_c) begin
            adv_r_c    = 1'b1;
            cnt_next_c = '0;
          end else if (cnt_done_c) begin
            accept_c   = 1'b1;
            cnt_next_c = '0;
          end else begin
            cnt_next_c = cnt_inc_c;
          end
        end
        ST_PRESSED: begin
          cnt_next_c = '0;
        end
        ST_RELEASE: begin
          if (dec_c.single) begin
            cnt_next_c = '0;
          end else if (cnt_done_c) begin
            adv_r_c    = 1'b1;
            cnt_next_c = '0;
          end else begin
            cnt_next_c = cnt_inc_c;
          end
        end
        default: cnt_next_c = '0;
      endcase
    end
  end

  // Row pointer, registered row drive, candidate and match counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r    <= 2'd0;
      ROW  <= 4'b1110;
      cand <= '0;
      cnt  <= '0;
    end else begin
      if (adv_r_c) begin
        r   <= r + 2'd1;
        ROW <= row_drive(r + 2'd1);
      end
      if (cand_load_c) begin
        cand <= sample_code_c;
      end
      cnt <= cnt_next_c;
    end
  end

  // Key event and entered-number register; clr only clears the number
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      hexs      <= '0;
    end else begin
      key_valid <= accept_c;
      if (accept_c) begin
        key_code <= sample_code_c;
      end
      if (clr) begin
        hexs <= '0;
      end else if (accept_c) begin
        hexs <= {hexs[HEX_W-CODE_W-1:0], sample_code_c};
      end
    end
  end

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed bench for keypad_number_entry with a resistive-matrix keypad model.
module tb_keypad_number_entry;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] hexs;
  logic [3:0]  key_code;
  logic        key_valid;

  logic [15:0] keys;
  int          checks;
  int          errors;
  int          pulses;
  int          p0;

  keypad_number_entry #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .COL       (col),
    .ROW       (row),
    .hexs      (hexs),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven low
  always_comb begin
    col = 4'b1111;
    for (int rr = 0; rr < 4; rr++) begin
      for (int cc = 0; cc < 4; cc++) begin
        if (keys[4*rr+cc] && !row[rr]) col[cc] = 1'b0;
      end
    end
  end

  // Count every cycle key_valid is high
  always @(posedge clk) begin
    if (key_valid === 1'b1) pulses <= pulses + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dwells(input int n);
    repeat (4*n) @(negedge clk);
  endtask

  // Advance dwell by dwell until the scanner drives row r (bounded)
  task automatic wait_row(input logic [1:0] r);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << r);
    n = 0;
    while (row !== want && n < 16) begin
      dwells(1);
      n++;
    end
    check("wait_row", 16'(row), 16'(want));
  endtask

  // Press a key when its row comes up, hold, release, wait back to scanning
  task automatic press_key(input logic [3:0] code, input int hold, input int rel);
    wait_row(code[3:2]);
    keys = 16'(1) << code;
    dwells(hold);
    keys = 16'h0000;
    dwells(rel);
  endtask

  // One-cycle clr pulse, then realign to the dwell grid
  task automatic clear_hexs();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_hexs", hexs, 16'h0000);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_rows [4];
    logic [3:0] digits [5];
    logic [15:0] exp_hex [5];
    exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    digits   = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    exp_hex  = '{16'h0001, 16'h0012, 16'h0123, 16'h1234, 16'h2345};
    checks = 0;
    errors = 0;
    pulses = 0;
    keys   = 16'h0000;
    clr    = 1'b0;
    rst    = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_row", 16'(row), 16'h000E);
    check("rst_hexs", hexs, 16'h0000);
    check("rst_key_code", 16'(key_code), 16'h0000);
    check("rst_key_valid", 16'(key_valid), 16'h0000);
    rst = 1'b0;

    // Idle scan: one row per 4-clock dwell
    check("scan_row0", 16'(row), 16'(exp_rows[0]));
    for (int i = 1; i <= 4; i++) begin
      dwells(1);
      check($sformatf("scan_row_step%0d", i), 16'(row), 16'(exp_rows[i % 4]));
    end
    check("scan_hexs", hexs, 16'h0000);
    check("scan_no_valid", 16'(pulses), 16'd0);

    // Single press of key 6 (row 1, col 2) held 8 dwells; exact acceptance cycle
    p0 = pulses;
    keys = 16'(1) << 6;
    repeat (15) @(negedge clk);
    check("k6_before_accept", 16'(key_valid), 16'h0000);
    @(negedge clk);
    check("k6_accept", 16'(key_valid), 16'h0001);
    check("k6_code", 16'(key_code), 16'h0006);
    dwells(4);
    keys = 16'h0000;
    dwells(4);
    check("k6_one_pulse", 16'(pulses - p0), 16'd1);
    check("k6_hexs", hexs, 16'h0006);

    // Digit entry 1..5 shifting through the four-digit register
    clear_hexs();
    for (int i = 0; i < 5; i++) begin
      p0 = pulses;
      press_key(digits[i], 4, 4);
      check($sformatf("entry_pulse%0d", i), 16'(pulses - p0), 16'd1);
      check($sformatf("entry_code%0d", i), 16'(key_code), 16'(digits[i]));
      check($sformatf("entry_hexs%0d", i), hexs, exp_hex[i]);
    end

    // Bounce: key A seen 2 samples, gone 1, seen 2 -> rejected
    p0 = pulses;
    for (int i = 0; i < 2; i++) begin
      wait_row(2'd2);
      keys = 16'(1) << 10;
      dwells(2);
      keys = 16'h0000;
      dwells(1);
    end
    check("bounce_no_valid", 16'(pulses - p0), 16'd0);
    wait_row(2'd2);
    keys = 16'(1) << 10;
    dwells(3);
    check("bounce_clean_valid", 16'(key_valid), 16'h0001);
    check("bounce_clean_code", 16'(key_code), 16'h000A);
    dwells(1);
    keys = 16'h0000;
    dwells(4);
    check("bounce_one_pulse", 16'(pulses - p0), 16'd1);
    check("bounce_hexs", hexs, 16'h345A);

    // Ghosting: two columns low in row 0 is never a key
    p0 = pulses;
    wait_row(2'd0);
    keys = 16'h0003;
    dwells(6);
    keys = 16'h0000;
    dwells(2);
    check("ghost_no_valid", 16'(pulses - p0), 16'd0);

    // clr coinciding with acceptance of key 7: number clears, event still reported
    clear_hexs();
    press_key(4'h1, 4, 4);
    press_key(4'h2, 4, 4);
    press_key(4'h3, 4, 4);
    check("pre_clr_hexs", hexs, 16'h0123);
    p0 = pulses;
    wait_row(2'd1);
    keys = 16'(1) << 7;
    repeat (11) @(negedge clk);
    check("k7_before_accept", 16'(key_valid), 16'h0000);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("k7_valid", 16'(key_valid), 16'h0001);
    check("k7_code", 16'(key_code), 16'h0007);
    check("k7_clr_hexs", hexs, 16'h0000);
    dwells(1);
    keys = 16'h0000;
    dwells(4);
    check("k7_one_pulse", 16'(pulses - p0), 16'd1);
    check("k7_hexs_after", hexs, 16'h0000);

    // Reset mid-debounce of key 5, key held through and after reset
    p0 = pulses;
    wait_row(2'd1);
    keys = 16'(1) << 5;
    dwells(1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    check("midrst_row", 16'(row), 16'h000E);
    check("midrst_hexs", hexs, 16'h0000);
    check("midrst_valid", 16'(key_valid), 16'h0000);
    check("midrst_code", 16'(key_code), 16'h0000);
    rst = 1'b0;
    clr = 1'b0;
    repeat (15) @(negedge clk);
    check("k5_before_accept", 16'(key_valid), 16'h0000);
    @(negedge clk);
    check("k5_valid", 16'(key_valid), 16'h0001);
    check("k5_code", 16'(key_code), 16'h0005);
    check("k5_hexs", hexs, 16'h0005);
    dwells(1);
    keys = 16'h0000;
    dwells(4);
    check("k5_one_pulse", 16'(pulses - p0), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
